// File: rtl/cpx_spc_pkt_buf_if.sv
// CPX return-packet buffer bus: CX3 packet input, consumer pop handshake, and status.
// The master is the CPX/consumer side and the slave is the buffer.
interface cpx_spc_pkt_buf_if #(
  parameter int CPX_WIDTH = 145,
  parameter int DEPTH     = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CPX_WIDTH-1:0] cpx_spc_data_cx3;
  logic                 cpx_spc_data_rdy_cx3;
  logic                 cpx_pkt_rd;
  logic                 cpx_pkt_vld;
  logic [CPX_WIDTH-1:0] cpx_pkt_data;
  logic [3:0]           cpx_pkt_rtntyp;
  logic [CNT_W-1:0]     cpx_buf_cnt;
  logic                 cpx_buf_hwm;
  logic                 cpx_buf_ovf_err;

  modport master (
    output cpx_spc_data_cx3, cpx_spc_data_rdy_cx3, cpx_pkt_rd,
    input  cpx_pkt_vld, cpx_pkt_data, cpx_pkt_rtntyp,
           cpx_buf_cnt, cpx_buf_hwm, cpx_buf_ovf_err
  );

  modport slave (
    input  cpx_spc_data_cx3, cpx_spc_data_rdy_cx3, cpx_pkt_rd,
    output cpx_pkt_vld, cpx_pkt_data, cpx_pkt_rtntyp,
           cpx_buf_cnt, cpx_buf_hwm, cpx_buf_ovf_err
  );
endinterface

// File: rtl/cpx_spc_pkt_buf.sv
// Core-side CPX return-packet FIFO with a registered head, a high-water flag
// and a sticky overflow error (the CPX cannot be back-pressured).
module cpx_spc_pkt_buf #(
  parameter int DEPTH     = 4,
  parameter int HWM       = 3,
  parameter int CPX_WIDTH = 145
) (
  input logic              rclk,
  input logic              arst_l,
  cpx_spc_pkt_buf_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CPX_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wp, rp, wp_nxt, rp_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CPX_WIDTH-1:0] data_q, head_nxt;
  logic                 hwm_q, ovf_q;
  logic                 enq, deq, full, wr_en, drop;

  assign enq   = bus.cpx_spc_data_rdy_cx3 & bus.cpx_spc_data_cx3[CPX_WIDTH-1];
  assign deq   = bus.cpx_pkt_rd & (cnt != '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  // At full, a write is only accepted when a dequeue frees the head slot.
  assign wr_en = enq & (~full | deq);
  assign drop  = enq & full & ~deq;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_en && !deq)
      cnt_nxt = cnt + CNT_W'(1);
    else if (deq && !wr_en)
      cnt_nxt = cnt - CNT_W'(1);
  end

  assign wp_nxt = wr_en ? wp + PTR_W'(1) : wp;
  assign rp_nxt = deq   ? rp + PTR_W'(1) : rp;

  // The next head may be the packet being written this very edge.
  assign head_nxt = (wr_en && (wp == rp_nxt)) ? bus.cpx_spc_data_cx3 : mem[rp_nxt];

  always_ff @(posedge rclk) begin
    if (wr_en)
      mem[wp] <= bus.cpx_spc_data_cx3;
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      data_q <= '0;
      hwm_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wp    <= wp_nxt;
      rp    <= rp_nxt;
      cnt   <= cnt_nxt;
      hwm_q <= (cnt_nxt >= CNT_W'(HWM));
      if (drop)
        ovf_q <= 1'b1;
      // Hold the head while empty so it never goes back to stale storage.
      if (cnt_nxt != '0)
        data_q <= head_nxt;
    end
  end

  assign bus.cpx_pkt_vld     = (cnt != '0);
  assign bus.cpx_pkt_data    = data_q;
  assign bus.cpx_pkt_rtntyp  = data_q[CPX_WIDTH-2 -: 4];
  assign bus.cpx_buf_cnt     = cnt;
  assign bus.cpx_buf_hwm     = hwm_q;
  assign bus.cpx_buf_ovf_err = ovf_q;
endmodule

// File: tb/tb_cpx_spc_pkt_buf.sv
// Directed self-checking bench for cpx_spc_pkt_buf (DEPTH=4, HWM=3).
module tb_cpx_spc_pkt_buf;
  localparam int W = 145;

  logic rclk = 1'b0;
  logic arst_l = 1'b0;
  int   total = 0;
  int   bad = 0;

  cpx_spc_pkt_buf_if #(.CPX_WIDTH(W), .DEPTH(4)) bus ();

  cpx_spc_pkt_buf #(.DEPTH(4), .HWM(3), .CPX_WIDTH(W)) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  function automatic logic [W-1:0] mkpkt(input int k);
    return {1'b1, 4'(k), 108'h0, 32'hDEAD_0000 | 32'(k)};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rdy, input logic [W-1:0] data, input logic rd);
    bus.cpx_spc_data_rdy_cx3 = rdy;
    bus.cpx_spc_data_cx3     = data;
    bus.cpx_pkt_rd           = rd;
    @(posedge rclk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input int cnt, input logic hwm, input logic ovf);
    checkOutput({tag, "_cnt"}, W'(bus.cpx_buf_cnt), W'(cnt));
    checkOutput({tag, "_vld"}, W'(bus.cpx_pkt_vld), W'(cnt != 0));
    checkOutput({tag, "_hwm"}, W'(bus.cpx_buf_hwm), W'(hwm));
    checkOutput({tag, "_ovf"}, W'(bus.cpx_buf_ovf_err), W'(ovf));
  endtask

  logic [W-1:0] exp_q[$];
  logic [W-1:0] pkt_ab;
  logic [W-1:0] f [6];
  logic         do_enq, do_rd;
  int           enq_n;

  initial begin
    bus.cpx_spc_data_rdy_cx3 = 1'b0;
    bus.cpx_spc_data_cx3     = '0;
    bus.cpx_pkt_rd           = 1'b0;
    pkt_ab = {1'b1, 144'hAB};

    // Power-on reset
    repeat (2) @(posedge rclk);
    #1;
    checkStatus("por", 0, 1'b0, 1'b0);
    checkOutput("por_data", bus.cpx_pkt_data, '0);
    checkOutput("por_rtntyp", W'(bus.cpx_pkt_rtntyp), '0);
    @(negedge rclk);
    arst_l = 1'b1;

    // Strobe without bit 144 is ignored
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, {1'b0, 144'h5A5A}, 1'b0);
      checkStatus("novld", 0, 1'b0, 1'b0);
    end

    // Reads while empty do not underflow
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkStatus("emptyrd", 0, 1'b0, 1'b0);
    end

    // High-water: three enqueues, then one read
    applyStimulus(1'b1, mkpkt(1), 1'b0);
    checkStatus("hwm1", 1, 1'b0, 1'b0);
    checkOutput("hwm1_data", bus.cpx_pkt_data, mkpkt(1));
    applyStimulus(1'b1, mkpkt(2), 1'b0);
    checkStatus("hwm2", 2, 1'b0, 1'b0);
    applyStimulus(1'b1, mkpkt(3), 1'b0);
    checkStatus("hwm3", 3, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkStatus("hwm_rd", 2, 1'b0, 1'b0);
    checkOutput("hwm_rd_data", bus.cpx_pkt_data, mkpkt(2));
    applyStimulus(1'b1, mkpkt(4), 1'b0);
    checkStatus("prerst", 3, 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    bus.cpx_spc_data_rdy_cx3 = 1'b0;
    #2 arst_l = 1'b0;
    #1;
    checkStatus("midrst", 0, 1'b0, 1'b0);
    checkOutput("midrst_data", bus.cpx_pkt_data, '0);
    @(negedge rclk);
    arst_l = 1'b1;
    applyStimulus(1'b1, pkt_ab, 1'b0);
    checkStatus("postrst", 1, 1'b0, 1'b0);
    checkOutput("postrst_data", bus.cpx_pkt_data, pkt_ab);
    applyStimulus(1'b0, '0, 1'b1);
    checkStatus("postrst_drain", 0, 1'b0, 1'b0);

    // Ordering and pointer wrap against a queue model
    enq_n = 0;
    exp_q.delete();
    for (int c = 0; c < 60 && (enq_n < 10 || exp_q.size() != 0); c++) begin
      do_enq = (enq_n < 10) && (c % 3 != 2);
      do_rd  = (enq_n < 10) ? (c % 2 == 1) : 1'b1;
      if (do_rd && exp_q.size() != 0) begin
        checkOutput("ord_data", bus.cpx_pkt_data, exp_q[0]);
        checkOutput("ord_rtntyp", W'(bus.cpx_pkt_rtntyp), W'(exp_q[0][143:140]));
        void'(exp_q.pop_front());
      end
      if (do_enq) exp_q.push_back(mkpkt(enq_n));
      applyStimulus(do_enq, do_enq ? mkpkt(enq_n) : '0, do_rd);
      if (do_enq) enq_n++;
      checkStatus("ord", exp_q.size(), exp_q.size() >= 3, 1'b0);
    end
    checkOutput("ord_complete", W'(enq_n == 10 && exp_q.size() == 0), W'(1));

    // Full boundary: drop at full, then enqueue+read at full
    for (int i = 0; i < 6; i++) f[i] = mkpkt(16 + i);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, f[i], 1'b0);
    checkStatus("full", 4, 1'b1, 1'b0);
    applyStimulus(1'b1, f[4], 1'b0);
    checkStatus("drop", 4, 1'b1, 1'b1);
    checkOutput("drop_head", bus.cpx_pkt_data, f[0]);
    applyStimulus(1'b1, f[5], 1'b1);
    checkStatus("fullrw", 4, 1'b1, 1'b1);
    checkOutput("fullrw_head", bus.cpx_pkt_data, f[1]);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("full_d2", bus.cpx_pkt_data, f[2]);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("full_d3", bus.cpx_pkt_data, f[3]);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("full_d5", bus.cpx_pkt_data, f[5]);
    checkStatus("full_last", 1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkStatus("full_empty", 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpx_spc_pkt_buf.md
# cpx_spc_pkt_buf

Core-side CPX return-packet buffer that sits directly downstream of the CPX-to-SPARC repeater stage. It captures each valid 145-bit CPX packet presented in CX3, queues it in a small FIFO, and hands it to the LSU/IFU return-packet consumer through a valid/read handshake. The CPX cannot be back-pressured, so the block provides a high-water indication for upstream throttling and a sticky overflow error.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, minimum 2.
- `HWM`, 3: occupancy at or above which `cpx_buf_hwm` asserts. Legal range 1..DEPTH.
- `rclk` input 1: core clock. All flops are on the rising edge.
- `arst_l` input 1: reset. One clock; reset is asynchronous and active-low.
- `cpx_spc_data_cx3` input 145 (`CPX_WIDTH`): CPX packet. Bit 144 is the valid bit; bits 143:140 are rtntyp.
- `cpx_spc_data_rdy_cx3` input 1: packet strobe for the current cycle.
- `cpx_pkt_rd` input 1: consumer pops the head entry this cycle.
- `cpx_pkt_vld` output 1: head entry is valid.
- `cpx_pkt_data` output 145: head packet. Registered output.
- `cpx_pkt_rtntyp` output 4: `cpx_pkt_data[143:140]`.
- `cpx_buf_cnt` output $clog2(DEPTH)+1: current occupancy.
- `cpx_buf_hwm` output 1: high-water flag. Registered.
- `cpx_buf_ovf_err` output 1: sticky overflow error.

## Operation
- Enqueue qualifier: `enq = cpx_spc_data_rdy_cx3 & cpx_spc_data_cx3[144]`. A strobe with bit 144 clear is ignored and is not counted.
- Dequeue qualifier: `deq = cpx_pkt_rd & cpx_pkt_vld`. A read while empty is ignored.
- Storage is a circular buffer with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits, and an occupancy counter `cnt` of `$clog2(DEPTH)+1` bits.
  - Both pointers wrap modulo DEPTH with no special case.
- `cnt` update rule:
  - `enq & ~deq`: cnt+1.
  - `deq & ~enq`: cnt-1.
  - Both or neither: unchanged.
- Full (`cnt==DEPTH`):
  - `enq & deq`: the write is accepted into the slot freed by the dequeue, and cnt stays at DEPTH.
  - `enq & ~deq`: the packet is dropped. `wp` and `cnt` are unchanged, and `cpx_buf_ovf_err` sets.
- Empty (`cnt==0`) with `enq`: the packet is written to storage, and `cpx_pkt_vld` rises the next cycle. There is no combinational bypass.
- The head output is the storage entry at `rp`.
  - `cpx_pkt_data` is held when the buffer is empty. It is don't-care but must not be X after the first write.
- `cpx_buf_hwm` is registered from the next-state count: `hwm <= (cnt_nxt >= HWM)`.
- `cpx_buf_ovf_err` is cleared only by `arst_l`.
- Reset values:
  - `wp=0`, `rp=0`, `cnt=0`.
  - `cpx_pkt_vld=0`, `cpx_buf_cnt=0`, `cpx_buf_hwm=0`, `cpx_buf_ovf_err=0`.
  - `cpx_pkt_data=0` and `cpx_pkt_rtntyp=0`.
  - Storage array is not reset.
- Reset asserted mid-operation discards all queued packets immediately (asynchronously). The first enqueue after deassertion behaves as enqueue into an empty buffer.

## Timing
- Enqueue latency: a packet sampled at edge N is visible on `cpx_pkt_data` with `cpx_pkt_vld=1` after edge N, i.e. in cycle N+1. This holds only if it is the head entry.
- Dequeue: `cpx_pkt_rd` high in cycle N means the next entry (if any) is presented after edge N. Back-to-back reads every cycle are supported.
- Throughput is one enqueue and one dequeue per cycle, simultaneously.
- `cpx_buf_cnt`, `cpx_buf_hwm` and `cpx_buf_ovf_err` all reflect the state after the same edge. `cpx_buf_ovf_err` rises the cycle after the dropped strobe.
- `cpx_pkt_vld` is equivalent to `cnt!=0`. No output depends combinationally on any input.
- Reset deassertion is assumed synchronized externally. The first functional edge is the first edge with `arst_l=1`.

## Test plan
- **Reset:** drive `arst_l=0` mid-stream with cnt=3 → within the reset cycle vld=0, cnt=0, hwm=0, ovf=0. After release, enqueue 145'h1_0000...00AB → vld=1 next cycle with data 145'h1_0000...00AB.
- **Ordering and wrap:** DEPTH=4. Enqueue packets P0..P9 (bit144=1, rtntyp=0..9 mod 16) while reading every other cycle → all 10 emerge in order, rtntyp matches, pointers wrap at least twice, ovf stays 0.
- **Valid qualifier:** rdy=1 with bit144=0 for 5 cycles → cnt stays 0 and vld stays 0.
- **Full boundary:** fill to 4 with no reads, then a 5th enqueue → cnt=4, ovf=1 next cycle, and the head is still P0 with the 5th packet lost. Next, enqueue plus read in the same cycle at full → cnt=4, ovf remains 1, and the new packet appears after the remaining three.
- **High water:** HWM=3. Enqueue 3 → hwm=1 after the third edge. One read → hwm=0 after that edge.
- **Empty read:** `cpx_pkt_rd=1` for 3 cycles with cnt=0 → cnt stays 0 (no underflow to all-ones) and vld=0.
